game_timer_sseg: RTL and testbench

- Elapsed-game-time counter and 4-digit seven-segment driver for the Basys3 display.
- Counts whole seconds in BCD (0000-9999) under start/stop/clear control; tim_stop maps onto stop.
- Time-multiplexes the four digits onto the active-low sseg/an pins.
- Sits directly upstream of the board seg/an outputs, in the clk88MHz domain, instantiated inside the game top.

---
 rtl/game_timer_sseg.sv | 193 +++++++++++++++++++
 tb/tb_game_timer_sseg.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_sseg.sv
// Elapsed-game-time counter with a 4-digit multiplexed seven-segment driver.
// Counts whole seconds in BCD (0000-9999) under start/stop/clear control and
// scans the four digits onto the active-low Basys3 sseg/an pins.
//
// Handshake/control semantics: start and clear are single-cycle pulses, stop
// is a level. Per cycle the priority is rst > clear > stop > start. There is
// no valid/ready flow control; every input is acted on in the cycle it is
// sampled, and every output is a register.
module game_timer_sseg #(
    parameter int TICK_DIV = 88_000_000,
    parameter int MUX_DIV  = 88_000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] seconds_bcd,
    output logic        running,
    output logic        saturated,
    output logic [6:0]  sseg,
    output logic [3:0]  an,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = $clog2(MUX_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_next;
    logic            tick;
    logic            clr;
    logic            at_max;
    logic [15:0]     bcd_inc;
    logic            carry;

    logic [MW-1:0]   mux_cnt;
    logic [MW-1:0]   mux_cnt_next;
    logic [1:0]      idx;
    logic [1:0]      idx_next;
    logic [3:0]      digit_sel;
    logic [3:0]      blank_vec;
    logic [6:0]      seg_next;
    logic [3:0]      an_next;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign at_max    = (seconds_bcd == 16'h9999);
    assign fsm_state = state;

    // Next-state, prescaler and tick decision in control-priority order.
    always_comb begin
        state_next = state;
        presc_next = presc;
        tick       = 1'b0;
        clr        = 1'b0;
        if (clear) begin
            state_next = IDLE;
            presc_next = '0;
            clr        = 1'b1;
        end else if (state == RUN) begin
            if (stop) begin
                // Pause: prescaler keeps its phase until a fresh start reloads it.
                state_next = HALT;
            end else if (presc == PRESC_LAST) begin
                presc_next = '0;
                tick       = 1'b1;
                if (at_max) begin
                    state_next = HALT;
                end
            end else begin
                presc_next = presc + 1'b1;
            end
        end else if (start && !stop && !saturated) begin
            state_next = RUN;
            presc_next = '0;
        end
    end

    // BCD +1 with ripple carry; digits wrap 9 -> 0 and never exceed 9.
    always_comb begin
        bcd_inc = seconds_bcd;
        carry   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (seconds_bcd[4*k +: 4] >= 4'd9) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = seconds_bcd[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // State register, prescaler and running flag move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            running <= (state_next == RUN);
        end
    end

    // Seconds count and saturation flag; 9999 holds instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seconds_bcd <= 16'h0000;
            saturated   <= 1'b0;
        end else if (tick) begin
            if (at_max) begin
                saturated <= 1'b1;
            end else begin
                seconds_bcd <= bcd_inc;
            end
        end
    end

    // Scan timing: next mux count, digit index and the digit it selects.
    always_comb begin
        mux_cnt_next = mux_cnt + 1'b1;
        idx_next     = idx;
        if (mux_cnt == MUX_LAST) begin
            mux_cnt_next = '0;
            idx_next     = idx + 2'd1;
        end
        case (idx_next)
            2'd0:    digit_sel = seconds_bcd[3:0];
            2'd1:    digit_sel = seconds_bcd[7:4];
            2'd2:    digit_sel = seconds_bcd[11:8];
            default: digit_sel = seconds_bcd[15:12];
        endcase
        // A digit is a leading zero when it and everything above it are zero.
        blank_vec[3] = (seconds_bcd[15:12] == 4'd0);
        blank_vec[2] = blank_vec[3] && (seconds_bcd[11:8] == 4'd0);
        blank_vec[1] = blank_vec[2] && (seconds_bcd[7:4] == 4'd0);
        blank_vec[0] = 1'b0;
        if ((BLANK_LZ != 0) && blank_vec[idx_next]) begin
            seg_next = 7'b1111111;
        end else begin
            seg_next = seg_decode(digit_sel);
        end
        an_next = ~(4'b0001 << idx_next);
    end

    // Anode and cathode registers load together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_cnt <= '0;
            idx     <= 2'd0;
            an      <= 4'b1110;
            sseg    <= 7'b1000000;
        end else begin
            mux_cnt <= mux_cnt_next;
            idx     <= idx_next;
            an      <= an_next;
            sseg    <= seg_next;
        end
    end

endmodule

// File: tb/tb_game_timer_sseg.sv
// Bench for game_timer_sseg: main instance at TICK_DIV=10/MUX_DIV=4 with
// leading-zero blanking, plus a fast TICK_DIV=2 instance without blanking
// used to reach saturation in a short run.
module tb_game_timer_sseg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] seconds_bcd;
  logic        running;
  logic        saturated;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic [1:0]  fsm_state;

  logic        s_start = 1'b0;
  logic        s_stop = 1'b0;
  logic        s_clear = 1'b0;
  logic [15:0] s_bcd;
  logic        s_running;
  logic        s_saturated;
  logic [6:0]  s_sseg;
  logic [3:0]  s_an;
  logic [1:0]  s_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [6:0]  seg_tab [0:9];

  game_timer_sseg #(.TICK_DIV(10), .MUX_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .seconds_bcd(seconds_bcd), .running(running), .saturated(saturated),
    .sseg(sseg), .an(an), .fsm_state(fsm_state)
  );

  game_timer_sseg #(.TICK_DIV(2), .MUX_DIV(2), .BLANK_LZ(0)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .clear(s_clear),
    .seconds_bcd(s_bcd), .running(s_running), .saturated(s_saturated),
    .sseg(s_sseg), .an(s_an), .fsm_state(s_state)
  );

  // clock and cycles-since-reset counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // scan 16 cycles of the main display against a held count
  task automatic check_display(input logic [15:0] bcd);
    int i;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [15:0] upper;
    for (int n = 0; n < 16; n++) begin
      step();
      i = (cyc / 4) % 4;
      exp_an = ~(4'b0001 << i);
      upper = bcd >> (4 * i);
      if (i > 0 && upper == 16'h0000) exp_seg = 7'b1111111;
      else exp_seg = seg_tab[upper[3:0]];
      n_vec++;
      if (an !== exp_an) begin
        n_err++;
        $display("FAIL display_an cyc=%0d got=%b exp=%b", cyc, an, exp_an);
      end
      n_vec++;
      if (sseg !== exp_seg) begin
        n_err++;
        $display("FAIL display_sseg cyc=%0d an=%b got=%b exp=%b", cyc, an, sseg, exp_seg);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({seconds_bcd, running, saturated, an, sseg, fsm_state} !==
        {16'h0000, 1'b0, 1'b0, 4'b1110, 7'b1000000, S_IDLE}) begin
      n_err++;
      $display("FAIL reset_values got bcd=%h run=%b sat=%b an=%b sseg=%b st=%0d",
               seconds_bcd, running, saturated, an, sseg, fsm_state);
    end
    n_vec++;
    if ({s_bcd, s_running, s_saturated, s_an} !== {16'h0000, 1'b0, 1'b0, 4'b1110}) begin
      n_err++;
      $display("FAIL reset_values_sat got bcd=%h run=%b sat=%b an=%b",
               s_bcd, s_running, s_saturated, s_an);
    end
    rst = 1'b0;
    repeat (100) step();
    n_vec++;
    if (seconds_bcd !== 16'h0000 || running !== 1'b0) begin
      n_err++;
      $display("FAIL idle_100 got bcd=%h run=%b exp bcd=0000 run=0", seconds_bcd, running);
    end
    check_display(16'h0000);
  endtask

  task automatic test_start_count();
    logic [15:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    n_vec++;
    if (running !== 1'b1 || fsm_state !== S_RUN) begin
      n_err++;
      $display("FAIL start_running got run=%b st=%0d exp run=1 st=%0d", running, fsm_state, S_RUN);
    end
    for (int t = 1; t <= 2; t++) begin
      repeat (9) step();
      n_vec++;
      if (seconds_bcd !== to_bcd(t - 1)) begin
        n_err++;
        $display("FAIL pre_tick_%0d got=%h exp=%h", t, seconds_bcd, to_bcd(t - 1));
      end
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (seconds_bcd !== e) begin
        n_err++;
        $display("FAIL tick_%0d got=%h exp=%h", t, seconds_bcd, e);
      end
    end
  endtask

  task automatic test_stop_resume();
    repeat (3) step();
    stop = 1'b1;
    step();
    n_vec++;
    if (fsm_state !== S_HALT || running !== 1'b0) begin
      n_err++;
      $display("FAIL stop_halt got st=%0d run=%b exp st=%0d run=0", fsm_state, running, S_HALT);
    end
    repeat (24) step();
    stop = 1'b0;
    n_vec++;
    if (seconds_bcd !== 16'h0002) begin
      n_err++;
      $display("FAIL stop_frozen got=%h exp=0002", seconds_bcd);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(16'h0003);
    repeat (9) step();
    n_vec++;
    if (seconds_bcd !== 16'h0002) begin
      n_err++;
      $display("FAIL resume_early got=%h exp=0002", seconds_bcd);
    end
    step();
    n_vec++;
    if (seconds_bcd !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL resume_tick got=%h exp=0003", seconds_bcd);
    end
  endtask

  task automatic test_rollover();
    logic [15:0] e;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_vec++;
    if (seconds_bcd !== 16'h0000 || fsm_state !== S_IDLE) begin
      n_err++;
      $display("FAIL clear_run got bcd=%h st=%0d exp 0000/%0d", seconds_bcd, fsm_state, S_IDLE);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      exp_q.push_back(to_bcd(t));
      repeat (10) step();
      e = exp_q.pop_front();
      n_vec++;
      if (seconds_bcd !== e) begin
        n_err++;
        $display("FAIL count_%0d got=%h exp=%h", t, seconds_bcd, e);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_display(16'h0100);
  endtask

  task automatic test_same_cycle();
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    n_vec++;
    if (fsm_state !== S_IDLE || seconds_bcd !== 16'h0000 || running !== 1'b0) begin
      n_err++;
      $display("FAIL clear_start got st=%0d bcd=%h run=%b exp IDLE 0000 0",
               fsm_state, seconds_bcd, running);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    n_vec++;
    if (fsm_state !== S_HALT || running !== 1'b0) begin
      n_err++;
      $display("FAIL stop_start_halt got st=%0d run=%b exp st=%0d run=0", fsm_state, running, S_HALT);
    end
  endtask

  task automatic test_rst_mid_run();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (25) step();
    n_vec++;
    if (seconds_bcd !== 16'h0002 || running !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst_count got bcd=%h run=%b exp 0002 1", seconds_bcd, running);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({seconds_bcd, running, saturated, an, sseg, fsm_state} !==
        {16'h0000, 1'b0, 1'b0, 4'b1110, 7'b1000000, S_IDLE}) begin
      n_err++;
      $display("FAIL rst_mid_run got bcd=%h run=%b sat=%b an=%b sseg=%b st=%0d",
               seconds_bcd, running, saturated, an, sseg, fsm_state);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] e;
    int i;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int t = 1; t <= 9999; t++) begin
      exp_q.push_back(to_bcd(t));
      repeat (2) step();
      e = exp_q.pop_front();
      n_vec++;
      if (s_bcd !== e || s_saturated !== 1'b0) begin
        n_err++;
        $display("FAIL sat_count_%0d got=%h sat=%b exp=%h sat=0", t, s_bcd, s_saturated, e);
      end
    end
    repeat (2) step();
    n_vec++;
    if (s_bcd !== 16'h9999 || s_saturated !== 1'b1 || s_running !== 1'b0 || s_state !== S_HALT) begin
      n_err++;
      $display("FAIL saturate got bcd=%h sat=%b run=%b st=%0d exp 9999 1 0 %0d",
               s_bcd, s_saturated, s_running, s_state, S_HALT);
    end
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    repeat (5) step();
    n_vec++;
    if (s_bcd !== 16'h9999 || s_running !== 1'b0 || s_state !== S_HALT) begin
      n_err++;
      $display("FAIL sat_start_ignored got bcd=%h run=%b st=%0d", s_bcd, s_running, s_state);
    end
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    n_vec++;
    if (s_bcd !== 16'h0000 || s_saturated !== 1'b0 || s_state !== S_IDLE) begin
      n_err++;
      $display("FAIL sat_clear got bcd=%h sat=%b st=%0d exp 0000 0 %0d",
               s_bcd, s_saturated, s_state, S_IDLE);
    end
    step();
    for (int n = 0; n < 8; n++) begin
      step();
      i = (cyc / 2) % 4;
      n_vec++;
      if (s_an !== ~(4'b0001 << i) || s_sseg !== 7'b1000000) begin
        n_err++;
        $display("FAIL no_blank cyc=%0d got an=%b sseg=%b exp an=%b sseg=1000000",
                 cyc, s_an, s_sseg, ~(4'b0001 << i));
      end
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    test_reset();
    test_start_count();
    test_stop_resume();
    test_rollover();
    test_same_cycle();
    test_rst_mid_run();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
